hevc_in_flow_arbiter: RTL and testbench

Upstream stage of the multi-flow HEVC interpolation accelerator. It takes up to `FLUX` independent per-flow pel sources and buffers each one in a private FIFO. It merges them into the single tagged pel stream `{flow_id, pel}` that feeds the accelerator's `in_port` write interface, and it honours the accelerator's per-flow `full` vector. Per-flow block accounting (`ext_size²` pels per block) gates each source and signals block completion.

---
 rtl/hevc_in_flow_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_hevc_in_flow_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hevc_in_flow_arbiter.sv
// hevc_in_flow_arbiter
// Merges FLUX independent per-flow pel sources into one tagged {flow_id, pel}
// stream for the interpolation accelerator. Each flow has a private FIFO and a
// block-accounting FSM (IDLE -> LOAD -> DRAIN) that gates its source and pulses
// blk_done once ext_size^2 pels of the block have been emitted.
// Optional build macro: HEVC_ARB_STRICT_PRIO_EN -- fixed priority (highest
// eligible flow index wins) instead of round-robin arbitration.
module hevc_in_flow_arbiter #(
    parameter int DATA_W = 8,
    parameter int FLUX   = 2,
    parameter int DEPTH  = 16,
    localparam int TAG_W = $clog2(FLUX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLUX-1:0]         cfg_write,
    input  logic [6:0]              cfg_ext_size,
    input  logic [FLUX*DATA_W-1:0]  src_din,
    input  logic [FLUX-1:0]         src_write,
    output logic [FLUX-1:0]         src_full,
    output logic [TAG_W+DATA_W-1:0] out_din,
    output logic                    out_write,
    input  logic [FLUX-1:0]         out_full,
    output logic [FLUX-1:0]         blk_done,
    output logic [FLUX-1:0]         busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Block length is shared by all flows: ext_size squared, at most 127^2.
    logic [13:0] ext_sq;
    assign ext_sq = 14'(cfg_ext_size) * 14'(cfg_ext_size);

    logic [FLUX-1:0]        push;
    logic [FLUX-1:0]        pop;
    logic [FLUX-1:0]        eligible;
    logic [FLUX*DATA_W-1:0] head_flat;

    logic             grant_valid;
    logic [TAG_W-1:0] grant_idx;

    logic [TAG_W+DATA_W-1:0] out_din_reg;
    logic                    out_write_reg;

    genvar gi;
    generate
        for (gi = 0; gi < FLUX; gi++) begin : gen_flow
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;
            logic              fifo_full;

            state_t      state_reg, state_next;
            logic [13:0] in_left_reg, in_left_next;
            logic [13:0] out_left_reg, out_left_next;
            logic        done_reg, done_next;

            assign fifo_full = (count_reg == CNT_W'(DEPTH));
            assign src_full[gi] = fifo_full | (state_reg != ST_LOAD);
            assign push[gi] = src_write[gi] & ~src_full[gi];
            assign pop[gi]  = grant_valid && (grant_idx == TAG_W'(gi));
            assign eligible[gi] = (count_reg != '0) & ~out_full[gi];
            assign head_flat[gi*DATA_W +: DATA_W] = mem[rd_ptr_reg];
            assign busy[gi]     = (state_reg != ST_IDLE);
            assign blk_done[gi] = done_reg;

            // FIFO storage: contents are not reset, pointers define validity.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= src_din[gi*DATA_W +: DATA_W];
                end
            end

            // FIFO pointers and occupancy; simultaneous push/pop keeps count.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Block FSM state register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg    <= ST_IDLE;
                    in_left_reg  <= '0;
                    out_left_reg <= '0;
                    done_reg     <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    in_left_reg  <= in_left_next;
                    out_left_reg <= out_left_next;
                    done_reg     <= done_next;
                end
            end

            // Block FSM next state: count accepted pels in, emitted pels out.
            always_comb begin
                state_next    = state_reg;
                in_left_next  = in_left_reg;
                out_left_next = out_left_reg;
                done_next     = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (cfg_write[gi]) begin
                            if (ext_sq == '0) begin
                                done_next = 1'b1;
                            end else begin
                                state_next    = ST_LOAD;
                                in_left_next  = ext_sq;
                                out_left_next = ext_sq;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (push[gi]) begin
                            in_left_next = in_left_reg - 1'b1;
                            if (in_left_reg == 14'd1) state_next = ST_DRAIN;
                        end
                        if (pop[gi]) out_left_next = out_left_reg - 1'b1;
                    end
                    ST_DRAIN: begin
                        if (pop[gi]) begin
                            out_left_next = out_left_reg - 1'b1;
                            if (out_left_reg == 14'd1) begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                            end
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    endgenerate

`ifdef HEVC_ARB_STRICT_PRIO_EN
    // Fixed priority: the last (highest-index) eligible flow wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < FLUX; k++) begin
            if (eligible[k]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(k);
            end
        end
    end
`else
    logic [TAG_W-1:0] rr_ptr_reg;

    // Round-robin: search starts at the flow after the last grant.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= FLUX; k++) begin
            idx = (int'(rr_ptr_reg) + k) % FLUX;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_W'(idx);
            end
        end
    end

    // Remember the last granted flow; reset value makes flow 0 go first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= TAG_W'(FLUX - 1);
        end else if (grant_valid) begin
            rr_ptr_reg <= grant_idx;
        end
    end
`endif

    // Registered output stage: granted head is presented one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_din_reg   <= '0;
            out_write_reg <= 1'b0;
        end else begin
            out_write_reg <= grant_valid;
            if (grant_valid) begin
                out_din_reg <= {grant_idx, head_flat[int'(grant_idx)*DATA_W +: DATA_W]};
            end
        end
    end

    assign out_din   = out_din_reg;
    assign out_write = out_write_reg;

endmodule

// File: tb/tb_hevc_in_flow_arbiter.sv
// Self-checking bench for hevc_in_flow_arbiter (FLUX=2, DEPTH=16, DATA_W=8).
// Expected {flow, pel} words are queued per flow when the source handshake
// accepts a pel and compared when the DUT emits them.
module tb_hevc_in_flow_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cfg_write = '0;
    logic [6:0]  cfg_ext_size = '0;
    logic [15:0] src_din = '0;
    logic [1:0]  src_write = '0;
    logic [1:0]  src_full;
    logic [8:0]  out_din;
    logic        out_write;
    logic [1:0]  out_full = '0;
    logic [1:0]  blk_done;
    logic [1:0]  busy;

    hevc_in_flow_arbiter #(.DATA_W(8), .FLUX(2), .DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_write    (cfg_write),
        .cfg_ext_size (cfg_ext_size),
        .src_din      (src_din),
        .src_write    (src_write),
        .src_full     (src_full),
        .out_din      (out_din),
        .out_write    (out_write),
        .out_full     (out_full),
        .blk_done     (blk_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int  out_cnt[2];
    int  done_cnt[2];
    int  acc[2];
    int  full_at[2];
    int  first_in_cyc;
    int  first_out_cyc;
    bit  alt_on = 1'b0;
    int  alt_idx = 0;
    int  alt_base = 0;
    int  b0, b1, d0, d1;

    logic [8:0] mon_exp;
    logic       mon_tag;
    logic       mon_exp_tag;
    bit         mon_have;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pel_val(input int flow, input int k);
        if (flow == 1) return 8'(k);
        return 8'(k * 3 + 5);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: compare every emitted word against the flow's queue.
    always @(negedge clk) begin
        if (rst) begin
            if (out_write) begin
                mon_tag  = out_din[8];
                mon_have = 1'b0;
                mon_exp  = '0;
                if (mon_tag == 1'b0 && q0.size() > 0) begin
                    mon_exp = q0.pop_front(); mon_have = 1'b1;
                end else if (mon_tag == 1'b1 && q1.size() > 0) begin
                    mon_exp = q1.pop_front(); mon_have = 1'b1;
                end
                if (mon_have) check(mon_tag ? "out_f1" : "out_f0", 32'(out_din), 32'(mon_exp));
                else          check("unexpected_out", 32'(out_din), 32'h1000);
                if (alt_on) begin
`ifdef HEVC_ARB_STRICT_PRIO_EN
                    mon_exp_tag = ((alt_idx - alt_base) < 121) ? 1'b1 : 1'b0;
`else
                    mon_exp_tag = 1'(alt_idx - alt_base);
`endif
                    check("order_tag", 32'(mon_tag), 32'(mon_exp_tag));
                    alt_idx = alt_idx + 1;
                end
                out_cnt[mon_tag] = out_cnt[mon_tag] + 1;
            end
            for (int i = 0; i < 2; i++) begin
                if (blk_done[i]) begin
                    done_cnt[i] = done_cnt[i] + 1;
                    check("done_align", {30'd0, out_write, out_din[8]}, {30'd0, 1'b1, 1'(i)});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    task automatic cfg(input logic [1:0] mask, input logic [6:0] sz);
        @(negedge clk);
        cfg_write = mask;
        cfg_ext_size = sz;
        @(negedge clk);
        cfg_write = '0;
    endtask

    task automatic clear_acc();
        acc[0] = 0; acc[1] = 0;
        full_at[0] = -1; full_at[1] = -1;
        first_in_cyc = -1;
    endtask

    task automatic snap();
        b0 = out_cnt[0]; b1 = out_cnt[1];
        d0 = done_cnt[0]; d1 = done_cnt[1];
    endtask

    // Present pels on the masked flows; a pel counts as accepted when src_full
    // is low while it is presented, otherwise it is re-presented next cycle.
    task automatic feed(input logic [1:0] mask, input int nmax, input int maxc);
        bit any;
        logic [7:0] p;
        for (int c = 0; c <= maxc; c++) begin
            @(negedge clk);
            src_write = '0;
            if (c == maxc) break;
            any = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (mask[i] && acc[i] < nmax) begin
                    any = 1'b1;
                    p = pel_val(i, acc[i]);
                    src_write[i] = 1'b1;
                    src_din[i*8 +: 8] = p;
                    if (!src_full[i]) begin
                        if (i == 0) q0.push_back({1'b0, p});
                        else        q1.push_back({1'b1, p});
                        if (first_in_cyc < 0) first_in_cyc = cyc;
                        acc[i]++;
                    end else if (full_at[i] < 0) begin
                        full_at[i] = acc[i];
                    end
                end
            end
            if (!any) break;
        end
        src_write = '0;
    endtask

    task automatic wait_drain(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && busy == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        out_cnt[0] = 0; out_cnt[1] = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        clear_acc();

        // Reset values
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_out_din",  32'(out_din),   32'd0);
        check("rst_out_write",32'(out_write), 32'd0);
        check("rst_blk_done", 32'(blk_done),  32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_src_full", 32'(src_full),  32'd3);
        rst = 1'b1;

        // Single block on flow 1
        cfg(2'b10, 7'd11);
        check("cfg_busy",     32'(busy),     32'd2);
        check("cfg_src_full", 32'(src_full), 32'd1);
        clear_acc();
        snap();
        first_out_cyc = -1;
        fork
            feed(2'b10, 121, 300);
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (out_write) begin
                        first_out_cyc = cyc;
                        break;
                    end
                end
            end
        join
        check("src_full_after_blk", 32'(src_full), 32'd3);
        check("latency", 32'(first_out_cyc - first_in_cyc), 32'd2);
        wait_drain(100);
        check("single_cnt1",  32'(out_cnt[1] - b1), 32'd121);
        check("single_cnt0",  32'(out_cnt[0] - b0), 32'd0);
        check("single_done1", 32'(done_cnt[1] - d1), 32'd1);

        // Interleave: both flows fed every cycle
        clear_acc();
        snap();
        alt_base = alt_idx;
        alt_on = 1'b1;
        cfg(2'b11, 7'd11);
        feed(2'b11, 121, 700);
        wait_drain(300);
        alt_on = 1'b0;
        check("inter_cnt0",  32'(out_cnt[0] - b0), 32'd121);
        check("inter_cnt1",  32'(out_cnt[1] - b1), 32'd121);
        check("inter_done0", 32'(done_cnt[0] - d0), 32'd1);
        check("inter_done1", 32'(done_cnt[1] - d1), 32'd1);

        // Back-pressure on flow 0
        clear_acc();
        snap();
        out_full = 2'b01;
        cfg(2'b11, 7'd11);
        feed(2'b11, 121, 300);
        check("bp_acc0",     32'(acc[0]), 32'd16);
        check("bp_full_at0", 32'(full_at[0]), 32'd16);
        check("bp_cnt0",     32'(out_cnt[0] - b0), 32'd0);
        check("bp_cnt1",     32'(out_cnt[1] - b1), 32'd121);
        out_full = 2'b00;
        feed(2'b01, 121, 400);
        wait_drain(200);
        check("bp_rel_cnt0", 32'(out_cnt[0] - b0), 32'd121);
        check("bp_done0",    32'(done_cnt[0] - d0), 32'd1);
        check("bp_done1",    32'(done_cnt[1] - d1), 32'd1);

        // Illegal inputs: pels while IDLE, cfg_write during LOAD
        snap();
        @(negedge clk);
        src_write = 2'b11;
        src_din = 16'hABCD;
        repeat (5) @(negedge clk);
        src_write = '0;
        repeat (3) @(negedge clk);
        check("idle_no_out", 32'(out_cnt[0] + out_cnt[1] - b0 - b1), 32'd0);
        check("idle_busy",   32'(busy), 32'd0);
        clear_acc();
        cfg(2'b10, 7'd11);
        feed(2'b10, 10, 50);
        cfg(2'b10, 7'd20);
        check("load_cfg_busy", 32'(busy), 32'd2);
        feed(2'b10, 200, 300);
        check("blk_len", 32'(acc[1]), 32'd121);
        wait_drain(100);
        check("illegal_cnt1",  32'(out_cnt[1] - b1), 32'd121);
        check("illegal_done1", 32'(done_cnt[1] - d1), 32'd1);

        // Mid-block asynchronous reset
        clear_acc();
        cfg(2'b10, 7'd11);
        feed(2'b10, 50, 100);
        #2 rst = 1'b0;
        #1;
        check("mrst_out_write", 32'(out_write), 32'd0);
        check("mrst_out_din",   32'(out_din),   32'd0);
        check("mrst_busy",      32'(busy),      32'd0);
        check("mrst_src_full",  32'(src_full),  32'd3);
        check("mrst_blk_done",  32'(blk_done),  32'd0);
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_acc();
        snap();
        cfg(2'b10, 7'd11);
        feed(2'b10, 200, 300);
        wait_drain(100);
        check("fresh_acc1",  32'(acc[1]), 32'd121);
        check("fresh_cnt1",  32'(out_cnt[1] - b1), 32'd121);
        check("fresh_done1", 32'(done_cnt[1] - d1), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
